// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a 2^ADDR_W x 32 word array; independent single-outstanding read/write FSMs.
// Optional byte-lane strobes: define AXI_SLV_WSTRB_EN to honour wstrb, otherwise full-word writes.
module axi_sram_slave #(
    parameter int          ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h0000_0000,
    parameter int          RD_LAT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [2:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [2:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [31:0] mem [2**ADDR_W];

    // Holds the address-channel readies low for the first cycle after reset.
    logic up;

    w_state_t          w_state, w_next;
    logic [3:0]        w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic              w_err;

    r_state_t          r_state, r_next;
    logic [3:0]        r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic              r_err;
    logic [3:0]        lat_cnt;

    logic aw_hs, w_hs, ar_hs, r_hs;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    function automatic logic hdr_err(logic [31:0] addr, logic [1:0] burst, logic [2:0] size);
        return (addr[31:ADDR_W+2] != BASE[31:ADDR_W+2]) || (burst != 2'b01) || (size != 3'b010);
    endfunction

    logic unused;
    assign unused = ^{wid, awlock, awcache, awprot, arlock, arcache, arprot,
                      awaddr[1:0], araddr[1:0], wstrb};

    assign bid = w_id;
    assign rid = r_id;

    always_ff @(posedge clk) begin
        if (reset) up <= 1'b0;
        else       up <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_id   <= awid;
                w_addr <= awaddr[ADDR_W+1:2];
                w_len  <= awlen;
                w_cnt  <= '0;
                w_err  <= hdr_err(awaddr, awburst, awsize);
            end
            if (w_hs) begin
                w_addr <= w_addr + 1'b1;
                w_cnt  <= w_cnt + 8'd1;
                // Short or long bursts are only detectable once wlast arrives.
                if (wlast && (w_cnt != w_len)) w_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        case (w_state)
            W_IDLE: begin
                awready = up;
                if (awvalid && up) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = w_err ? 2'b10 : 2'b00;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && w_hs && !w_err) begin
`ifdef AXI_SLV_WSTRB_EN
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[w_addr][8*i +: 8] <= wdata[8*i +: 8];
`else
            mem[w_addr] <= wdata;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            lat_cnt <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_id    <= arid;
                r_addr  <= araddr[ADDR_W+1:2];
                r_len   <= arlen;
                r_cnt   <= '0;
                r_err   <= hdr_err(araddr, arburst, arsize);
                lat_cnt <= '0;
            end
            if (r_state == R_WAIT) lat_cnt <= lat_cnt + 4'd1;
            if (r_hs) begin
                r_addr <= r_addr + 1'b1;
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

    // Read data comes straight from the array so a same-cycle write shows up on the next beat.
    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = up;
                if (arvalid && up) r_next = (RD_LAT == 0) ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
                if (lat_cnt == 4'(RD_LAT - 1)) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rdata  = r_err ? 32'h0 : mem[r_addr];
                rresp  = r_err ? 2'b10 : 2'b00;
                rlast  = (r_cnt == r_len);
                if (rready && (r_cnt == r_len)) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector tables, hand sequences and random bursts
// against a word-array reference model of the memory.
module tb_axi_sram_slave;
    localparam int RD_LAT = 2;
    localparam int WORDS  = 4096;

    logic        clk = 1'b0, reset;
    logic [3:0]  awid;    logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
    logic [1:0]  awburst; logic [2:0]  awlock; logic [3:0] awcache; logic [2:0] awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;     logic [31:0] wdata;  logic [3:0] wstrb;  logic wlast, wvalid, wready;
    logic [3:0]  bid;     logic [1:0]  bresp;  logic bvalid, bready;
    logic [3:0]  arid;    logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
    logic [1:0]  arburst; logic [2:0]  arlock; logic [3:0] arcache; logic [2:0] arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;     logic [31:0] rdata;  logic [1:0] rresp; logic rlast, rvalid, rready;

    axi_sram_slave #(.ADDR_W(12), .BASE(32'h0000_0000), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [31:0] ref_mem [WORDS];
    bit          known   [WORDS];

    typedef struct {
        logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [1:0] burst; logic [2:0] size;
        int nbeats; logic [31:0] d0; logic [1:0] exp_bresp;
    } wvec_t;
    typedef struct {
        logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [1:0] burst; logic [2:0] size;
        logic [1:0] exp_rresp;
    } rvec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // Reference rules: the array covers byte addresses 0..16K-1 above BASE=0; only INCR, 4-byte beats.
    function automatic bit hdr_bad(logic [31:0] addr, logic [1:0] burst, logic [2:0] size);
        return (addr >= 32'h4000) || (burst != 2'b01) || (size != 3'b010);
    endfunction

    function automatic int word_of(logic [31:0] addr, int beat);
        return int'(((addr >> 2) + 32'(beat)) % WORDS);
    endfunction

    function automatic logic rr(int mode, int t);
        case (mode)
            0:       return 1'b1;
            1:       return (t % 4 == 0) || (t % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input logic [31:0] data[$],
                            input logic [3:0] strb, input int bstall, input logic [1:0] exp_bresp);
        int t;
        bit herr = hdr_bad(addr, burst, size);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        // First beat is offered alongside AW; it must not be taken until the next cycle.
        wdata = data[0]; wstrb = strb; wlast = (data.size() == 1); wvalid = 1'b1;
        t = 0;
        while (!awready && t < 100) begin @(negedge clk); t++; end
        if (!awready) begin timeout("aw_handshake"); awvalid = 0; wvalid = 0; return; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < data.size(); i++) begin
            logic [31:0] d;
            int w;
            d = data[i];
            wdata = d; wlast = (i == data.size() - 1); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 100) begin @(negedge clk); t++; end
            if (!wready) begin timeout("w_handshake"); wvalid = 0; return; end
            @(negedge clk);
            if (!herr) begin
                w = word_of(addr, i);
`ifdef AXI_SLV_WSTRB_EN
                for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
`else
                ref_mem[w] = d;
`endif
                known[w] = 1'b1;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("b_after_wlast", 32'(bvalid), 32'd1);
        for (int s = 0; s < bstall; s++) begin
            chk("b_held", 32'(bvalid), 32'd1);
            chk("aw_blocked", 32'(awready), 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        if (!bvalid) begin timeout("b_wait"); bready = 0; return; end
        chk("bid", 32'(bid), 32'(id));
        chk("bresp", 32'(bresp), 32'(exp_bresp));
        @(negedge clk);
        bready = 1'b0;
        chk("b_done", 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int mode,
                           input logic [1:0] exp_rresp);
        int t, lat, b;
        bit held;
        logic [31:0] prev_d;
        logic prev_l;
        bit herr = hdr_bad(addr, burst, size);
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 100) begin @(negedge clk); t++; end
        if (!arready) begin timeout("ar_handshake"); arvalid = 0; return; end
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
        chk("rd_latency", 32'(lat), 32'(RD_LAT + 1));
        b = 0; t = 0; held = 0; prev_d = '0; prev_l = 0;
        rready = rr(mode, 0);
        while (b <= int'(len) && t < 2000) begin
            if (held) begin
                chk("r_hold_valid", 32'(rvalid), 32'd1);
                chk("r_hold_data", rdata, prev_d);
                chk("r_hold_last", 32'(rlast), 32'(prev_l));
            end
            if (rvalid && rready) begin
                int w = word_of(addr, b);
                if (herr) chk("rdata_err", rdata, 32'h0);
                else if (known[w]) chk("rdata", rdata, ref_mem[w]);
                chk("rresp", 32'(rresp), 32'(exp_rresp));
                chk("rlast", 32'(rlast), 32'(b == int'(len)));
                chk("rid", 32'(rid), 32'(id));
                b++;
                held = 0;
            end else if (rvalid) begin
                held = 1; prev_d = rdata; prev_l = rlast;
            end
            @(negedge clk);
            t++;
            rready = rr(mode, t);
        end
        if (b <= int'(len)) timeout("r_beats");
        rready = 1'b0;
        chk("r_idle", 32'(rvalid), 32'd0);
    endtask

    wvec_t wv[8];
    rvec_t rv[6];
    logic [31:0] q[$];
    logic [31:0] q2[$];

    initial begin
        int t;
        reset = 1'b1;
        {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
        {wid, wdata, wstrb, wlast, wvalid, bready} = '0;
        {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready} = '0;

        wv[0] = '{4'hF, 32'h10,        8'd3, 2'b01, 3'b010, 4, 32'hA0, 2'b00};
        wv[1] = '{4'h3, 32'h40,        8'd3, 2'b01, 3'b010, 3, 32'hB0, 2'b10};
        wv[2] = '{4'h1, 32'h80,        8'd1, 2'b01, 3'b010, 2, 32'hC0, 2'b00};
        wv[3] = '{4'h2, 32'h80,        8'd1, 2'b00, 3'b010, 2, 32'hD0, 2'b10};
        wv[4] = '{4'h5, 32'h0001_0000, 8'd0, 2'b01, 3'b010, 1, 32'hE0, 2'b10};
        wv[5] = '{4'h6, 32'h84,        8'd0, 2'b01, 3'b001, 1, 32'hF0, 2'b10};
        wv[6] = '{4'h7, 32'h3FFC,      8'd1, 2'b01, 3'b010, 2, 32'h55, 2'b00};
        wv[7] = '{4'h8, 32'h50,        8'd1, 2'b01, 3'b010, 3, 32'h66, 2'b10};
        rv[0] = '{4'hF, 32'h10,        8'd3, 2'b01, 3'b010, 2'b00};
        rv[1] = '{4'h1, 32'h80,        8'd1, 2'b01, 3'b010, 2'b00};
        rv[2] = '{4'h9, 32'h0002_0000, 8'd3, 2'b01, 3'b010, 2'b10};
        rv[3] = '{4'hA, 32'h3FFC,      8'd1, 2'b01, 3'b010, 2'b00};
        rv[4] = '{4'hB, 32'h10,        8'd3, 2'b10, 3'b010, 2'b10};
        rv[5] = '{4'h3, 32'h40,        8'd2, 2'b01, 3'b010, 2'b00};

        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_ids", 32'({bid, rid}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp_last", 32'({bresp, rresp, rlast}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("awready_up", 32'(awready), 32'd1);
        chk("arready_up", 32'(arready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            q.delete();
            for (int k = 0; k < wv[i].nbeats; k++) q.push_back(wv[i].d0 + 32'(k));
            do_write(wv[i].id, wv[i].addr, wv[i].len, wv[i].burst, wv[i].size, q, 4'hF, 0, wv[i].exp_bresp);
        end
        for (int i = 0; i < 6; i++)
            do_read(rv[i].id, rv[i].addr, rv[i].len, rv[i].burst, rv[i].size, 0, rv[i].exp_rresp);

        // R backpressure 1,0,0,1 and B backpressure for 5 cycles.
        do_read(4'h4, 32'h10, 8'd3, 2'b01, 3'b010, 1, 2'b00);
        q.delete(); q.push_back(32'h0BAD_F00D);
        do_write(4'hC, 32'h100, 8'd0, 2'b01, 3'b010, q, 4'hF, 5, 2'b00);

        // Partial strobe over an all-ones word.
        q.delete(); q.push_back(32'hFFFF_FFFF);
        do_write(4'hD, 32'h200, 8'd0, 2'b01, 3'b010, q, 4'hF, 0, 2'b00);
        q.delete(); q.push_back(32'h1234_5678);
        do_write(4'hD, 32'h200, 8'd0, 2'b01, 3'b010, q, 4'b0011, 0, 2'b00);
        do_read(4'hD, 32'h200, 8'd0, 2'b01, 3'b010, 0, 2'b00);

        for (int it = 0; it < 20; it++) begin
            logic [31:0] a = 32'($urandom_range(0, WORDS - 1)) << 2;
            logic [7:0]  l = 8'($urandom_range(0, 15));
            q.delete();
            for (int k = 0; k <= int'(l); k++) q.push_back($urandom);
            do_write(4'($urandom), a, l, 2'b01, 3'b010, q, 4'hF, $urandom_range(0, 3), 2'b00);
            do_read(4'($urandom), a, l, 2'b01, 3'b010, 2, 2'b00);
        end

        // Concurrent read of words 4..7 and write of words 8..11.
        q2.delete();
        for (int k = 0; k < 4; k++) q2.push_back(32'hC0DE_0000 + 32'(k));
        fork
            do_write(4'h2, 32'h20, 8'd3, 2'b01, 3'b010, q2, 4'hF, 0, 2'b00);
            do_read(4'h5, 32'h10, 8'd3, 2'b01, 3'b010, 0, 2'b00);
        join
        do_read(4'h6, 32'h20, 8'd3, 2'b01, 3'b010, 0, 2'b00);

        // Reset in the middle of a read burst.
        arid = 4'h7; araddr = 32'h10; arlen = 8'd3; arburst = 2'b01; arsize = 3'b010;
        arvalid = 1'b1; rready = 1'b1;
        t = 0;
        while (!arready && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 50) begin @(negedge clk); t++; end
        if (!rvalid) timeout("rst_mid_rvalid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
        chk("rst_mid_arready", 32'(arready), 32'd0);
        reset = 1'b0; rready = 1'b0;
        @(negedge clk);
        chk("rst_mid_arready_up", 32'(arready), 32'd1);
        chk("rst_mid_awready_up", 32'(awready), 32'd1);
        do_read(4'h8, 32'h10, 8'd3, 2'b01, 3'b010, 0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
